// File: rtl/probe_pkg.sv
// Shared types and constants for the probe clock controller.
package probe_pkg;

    localparam int CNT_W_DEF   = 32;
    localparam int BURST_W_DEF = 16;
    localparam int MIN_PERIOD  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/probe_clk_ctrl_if.sv
// Configuration handshake between command logic and the clock controller.
interface probe_clk_ctrl_if #(
    parameter int CNT_W   = 32,
    parameter int BURST_W = 16
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CNT_W-1:0]   cfg_period;
    logic [CNT_W-1:0]   cfg_high;
    logic [BURST_W-1:0] cfg_burst;

    modport master (
        output cfg_valid, cfg_period, cfg_high, cfg_burst,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_period, cfg_high, cfg_burst,
        output cfg_ready
    );
endinterface

// File: rtl/probe_clk_ctrl_period_counter.sv
// Free-running period counter: counts 0..period-1 while enabled, flags the last cycle.
module period_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    assign wrap = en && (count == period - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/probe_clk_ctrl.sv
// Square-wave sequencer: owns the divider, applies new settings only at period
// boundaries, and runs continuously or for a finite burst of periods.
module probe_clk_ctrl
    import probe_pkg::*;
#(
    parameter int               CNT_W      = CNT_W_DEF,
    parameter int               BURST_W    = BURST_W_DEF,
    parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(100000000),
    parameter logic [CNT_W-1:0] DEF_HIGH   = CNT_W'(50000000)
) (
    input  logic                clk,
    input  logic                rst_n,
    probe_clk_ctrl_if.slave     cfg,
    input  logic                start,
    input  logic                stop,
    output logic                square_out,
    output logic                busy,
    output logic                period_tick,
    output logic                done,
    output logic [BURST_W-1:0]  period_cnt
);

    function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
        return (p < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : p;
    endfunction

    // high=0 wins over high>=period so a zero request always means "low".
    function automatic logic [CNT_W-1:0] clamp_high(input logic [CNT_W-1:0] h,
                                                    input logic [CNT_W-1:0] p);
        if (h == '0)
            return '0;
        else if (h >= p)
            return clamp_period(p);
        else
            return h;
    endfunction

    state_e             state, nxt_state;
    logic [CNT_W-1:0]   act_period, act_high, nxt_period, nxt_high;
    logic [CNT_W-1:0]   pend_period, pend_high;
    logic [BURST_W-1:0] act_burst, nxt_burst, pend_burst, nxt_pc;
    logic               pend_valid;
    logic [CNT_W-1:0]   count, nxt_cnt;
    logic               wrap, run_en, start_go, copy, burst_end;
    logic               nxt_busy, nxt_tick, nxt_done;

    assign cfg.cfg_ready = !pend_valid;
    assign run_en        = (state != IDLE);
    assign start_go      = (state == IDLE) && start && !stop;

    period_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (run_en),
        .clr    (start_go),
        .period (act_period),
        .count  (count),
        .wrap   (wrap)
    );

    // Outputs are registered from next-cycle values so they line up with the counter.
    always_comb begin
        copy       = pend_valid && ((state == IDLE) || wrap);
        nxt_period = copy ? clamp_period(pend_period) : act_period;
        nxt_high   = copy ? clamp_high(pend_high, pend_period) : act_high;
        nxt_burst  = copy ? pend_burst : act_burst;
        burst_end  = (state == RUN) && wrap && (act_burst != '0) &&
                     (period_cnt == act_burst - BURST_W'(1));

        nxt_state = state;
        case (state)
            IDLE:    if (start_go) nxt_state = RUN;
            RUN:     if (burst_end) nxt_state = IDLE;
                     else if (stop) nxt_state = DRAIN;
            DRAIN:   if (wrap) nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase

        nxt_cnt = (start_go || wrap) ? '0 : (run_en ? count + CNT_W'(1) : count);

        nxt_pc = period_cnt;
        if (start_go)
            nxt_pc = '0;
        else if (wrap && !(&period_cnt))
            nxt_pc = period_cnt + BURST_W'(1);

        nxt_busy = (nxt_state != IDLE);
        nxt_tick = nxt_busy && (nxt_cnt == nxt_period - CNT_W'(1));
        nxt_done = nxt_tick && ((nxt_state == DRAIN) ||
                   ((nxt_state == RUN) && (nxt_burst != '0) &&
                    (nxt_pc == nxt_burst - BURST_W'(1))));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            act_period  <= DEF_PERIOD;
            act_high    <= DEF_HIGH;
            act_burst   <= '0;
            pend_valid  <= 1'b0;
            pend_period <= '0;
            pend_high   <= '0;
            pend_burst  <= '0;
            period_cnt  <= '0;
            square_out  <= 1'b0;
            busy        <= 1'b0;
            period_tick <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= nxt_state;
            act_period  <= nxt_period;
            act_high    <= nxt_high;
            act_burst   <= nxt_burst;
            period_cnt  <= nxt_pc;
            square_out  <= nxt_busy && (nxt_cnt < nxt_high);
            busy        <= nxt_busy;
            period_tick <= nxt_tick;
            done        <= nxt_done;
            if (cfg.cfg_valid && !pend_valid) begin
                pend_valid  <= 1'b1;
                pend_period <= cfg.cfg_period;
                pend_high   <= cfg.cfg_high;
                pend_burst  <= cfg.cfg_burst;
            end else if (copy) begin
                pend_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/probe_clk_ctrl.md
Name: probe_clk_ctrl

Overview:
- Controller/sequencer for a programmable period counter that generates a square wave with programmable high time.
- Accepts new period/high-time/burst settings through a valid/ready handshake and applies them only at a period boundary, so the output never glitches.
- Supports start/stop and finite bursts of N periods; reports period ticks and completion.
- Sits between the probe's register/command logic and the clock-output pins as the single owner of the divider datapath.

Parameters:
- CNT_W, 32, width of period, high-time and counter values.
- BURST_W, 16, width of burst count; 0 means continuous.
- DEF_PERIOD, 32'd100000000, active period after reset.
- DEF_HIGH, 32'd50000000, active high time after reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  new configuration offered
- cfg_ready  out  1  controller can accept a configuration (no pending shadow)
- cfg_period  in  CNT_W  period in clk cycles
- cfg_high  in  CNT_W  high time in clk cycles
- cfg_burst  in  BURST_W  number of periods to run; 0 = continuous
- start  in  1  single-cycle start request
- stop  in  1  single-cycle stop request
- square_out  out  1  registered waveform
- busy  out  1  high in RUN or DRAIN
- period_tick  out  1  one-cycle pulse on the last cycle of each period
- done  out  1  one-cycle pulse when returning to IDLE
- period_cnt  out  BURST_W  periods completed since start (saturating)

Behaviour:
- Reset, asynchronous: state IDLE, counter 0, active config = DEF_PERIOD/DEF_HIGH/0, no pending config.
- Reset values of outputs: square_out 0, busy 0, period_tick 0, done 0, period_cnt 0, cfg_ready 1.
- Reset mid-operation aborts immediately. No done pulse is issued.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready; the values are latched into the pending shadow and cfg_ready drops the next cycle.
  - In IDLE, a pending config is copied to active on the next cycle.
  - In RUN/DRAIN, a pending config is copied to active on the cycle the counter wraps (period_tick cycle).
  - cfg_ready returns to 1 the cycle after the copy.
- Clamping, applied at copy time:
  - period < 2 becomes 2.
  - high >= period gives a constant high output for the whole period.
  - high = 0 gives a constant low output.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN when start && !stop. Counter and period_cnt are cleared.
  - RUN -> DRAIN when stop.
  - RUN -> IDLE at the wrap on which period_cnt+1 == burst (burst != 0). done pulses that cycle.
  - DRAIN -> IDLE at the next wrap. done pulses that cycle.
  - start in RUN/DRAIN is ignored. stop in IDLE is ignored. start and stop in the same cycle: stop wins.
- Counter: runs 0..period-1 in RUN/DRAIN and wraps to 0. It is held at 0 in IDLE.
- Output timing:
  - square_out is registered = (state != IDLE) && (counter < high).
  - With start at cycle T: first counter 0 at T+1; square_out valid from T+1.
  - period_tick is high on the cycle where counter == period-1.
  - period_cnt increments on each wrap and saturates at all-ones.
- A pending config and a burst-terminating wrap in the same cycle: the config is copied to active, and the FSM still goes to IDLE.
- All arithmetic is unsigned CNT_W. There is no wrap-around hazard because comparisons use active registers only.

Decomposition:
- Shared package probe_pkg:
  - FSM state enum (IDLE/RUN/DRAIN).
  - CNT_W/BURST_W defaults.
  - MIN_PERIOD = 2.
- Sub-module period_counter (CNT_W):
  - Ports: clk, rst_n, en, clr, period; outputs count, wrap.
  - Holds the counter.
  - The FSM, shadow registers and output registers stay in probe_clk_ctrl.

Test Plan:
- period=4, high=2, burst=0, start -> square_out 1,1,0,0 repeating from T+1; period_tick every 4th cycle; busy=1.
- period=5, high=1, burst=3, start -> exactly 15 active cycles, 3 high pulses, done at cycle T+15, period_cnt=3, busy=0 afterwards.
- Running period=8; stop at counter=2 -> output continues to counter=7, done on that cycle, then square_out=0; same-cycle start+stop in IDLE -> stays IDLE.
- Running period=4; config period=6, high=3 sent at counter=1 -> cfg_ready low until the wrap; the next period shows 1,1,1,0,0,0; a second cfg_valid while pending is not accepted.
- config period=1, high=0 then period=3, high=5 -> first gives constant 0 with a 2-cycle tick; second gives constant 1 with a 3-cycle tick.
- rst_n low mid-RUN at counter=3 -> all outputs 0 asynchronously, no done; after release, DEF values are active and cfg_ready=1.
